// File: rtl/cyber_player_pkg.sv
// Shared types and constants for the tug-of-war computer opponent.
package cyber_pkg;

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_FIRE = 2'd1,
    S_DONE = 2'd2
  } cp_state_t;

  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

endpackage

// File: rtl/lfsr10.sv
// 10-bit XNOR Fibonacci LFSR; all-zero reset state is legal, 3FF is the unreachable lockup.
module lfsr10
  import cyber_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] q
);

  logic [9:0] q_q;
  logic [9:0] q_d;

  // Next-state: shift left, feedback is the XNOR of the two taps.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {q_q[8:0], ~(q_q[LFSR_TAP_A] ^ q_q[LFSR_TAP_B])};
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= 10'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cyber_player.sv
// Computer opponent: one decision per tick, presses when SW beats the LFSR,
// freezes permanently (until reset) once the playfield reports a winner.
module cyber_player
  import cyber_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int LFSR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] SW,
  input  logic [1:0]        winner,
  output logic              press,
  output logic [LFSR_W-1:0] lfsr_q
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  cp_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             press_q, press_d;
  logic             tick;
  logic             fire;
  logic             game_over;
  logic             lfsr_en;

  assign tick      = (count_q == CNT_LAST);
  assign fire      = (SW > lfsr_q);
  assign game_over = (winner != 2'b00);
  assign lfsr_en   = tick && (state_q != S_DONE);

  lfsr10 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .q     (lfsr_q)
  );

  // Tick divider; holds once the game is over so the frozen state is inspectable.
  always_comb begin
    count_d = count_q;
    if (state_q == S_DONE) begin
      count_d = count_q;
    end else if (tick) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Next-state logic; a winner takes priority over a firing tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (game_over) begin
          state_d = S_DONE;
        end else if (tick && fire) begin
          state_d = S_FIRE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FIRE: begin
        if (game_over) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_WAIT;
    endcase
    press_d = (state_d == S_FIRE);
  end

  // State, counter and press registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_WAIT;
      count_q <= '0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule
